ahbl_sram_ctrl: RTL and testbench
=================================

AHBL_SRAM_CTRL -- requirements
Module: ahbl_sram_ctrl

Interface
REQ-001 SHALL have port HCLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port HRESET  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port HSEL  input  1  slave select from the address decoder.
REQ-004 SHALL have port HADDR  input  32  byte address; only bits [12:0] are used.
REQ-005 SHALL have port HTRANS  input  2  transfer type.
REQ-006 SHALL have port HWRITE  input  1  1 = write.
REQ-007 SHALL have port HSIZE  input  3  transfer size.
REQ-008 SHALL have port HWDATA  input  64  write data, valid in the data phase.
REQ-009 SHALL have port HREADY  input  1  bus-level ready.
REQ-010 SHALL have port HREADYOUT  output  1  slave ready.
REQ-011 SHALL have port HRESP  output  1  1 = ERROR.
REQ-012 SHALL have port HRDATA  output  64  read data.
REQ-013 SHALL have port SRAMRDATA  input  64  RAM read data, registered by the RAM one cycle after CS.
REQ-014 SHALL have port SRAMWEN  output  8  per-byte write enables.
REQ-015 SHALL have port SRAMWDATA  output  64  RAM write data.
REQ-016 SHALL have port SRAMCS0  output  1  RAM enable.
REQ-017 SHALL have port SRAMADDR  output  10  RAM word address.

Function
REQ-018 SHALL accept a transfer only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ); IDLE/BUSY SHALL get zero-wait OKAY with no RAM access.
REQ-019 SHALL use word address HADDR[12:3]; HADDR[31:13] SHALL be ignored, so the 8 KB array aliases.
REQ-020 SHALL derive byte lanes little-endian from HSIZE and HADDR[2:0]:
  - HSIZE 0 -> 1 lane
  - HSIZE 1 -> 2 lanes
  - HSIZE 2 -> 4 lanes
  - HSIZE 3 -> all 8 lanes
REQ-021 SHALL treat HSIZE>3, or HADDR[2:0] not aligned to the size, as an error transfer.
REQ-022 SHALL implement FSM states IDLE, WR, RD, RDW, ERR1, ERR2.
REQ-023 Accepted valid write SHALL go to WR and latch address and lanes; in WR it SHALL drive SRAMCS0=1, SRAMWEN=latched lanes, SRAMADDR=latched address, SRAMWDATA=HWDATA, HREADYOUT=1.
REQ-024 Accepted valid read in a cycle not in WR SHALL drive, combinationally in the address phase, SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR[12:3], then go to RD.
REQ-025 In RD, HRDATA SHALL equal SRAMRDATA with HREADYOUT=1, giving zero wait states.
REQ-026 Read accepted while in WR (port collision) SHALL latch its address and go to RDW.
REQ-027 In RDW, HREADYOUT SHALL be 0 and the read SHALL be issued to the RAM from the latched address; the next state SHALL be RD, so the collision costs exactly one wait state.
REQ-028 Write after write and write after read SHALL have no wait states.
REQ-029 From WR or RD, the next accepted transfer SHALL decide the next state; otherwise the FSM SHALL go to IDLE.
REQ-030 Error transfer SHALL go to ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), with no RAM access.
REQ-031 A transfer accepted in ERR2 SHALL be handled as from IDLE.
REQ-032 HRDATA SHALL be 0 outside RD.
REQ-033 SRAMCS0 and SRAMWEN SHALL be 0 in every cycle without a RAM access.

Reset
REQ-034 HRESET=1 SHALL immediately force:
  - state IDLE
  - HREADYOUT=1, HRESP=0, HRDATA=0
  - SRAMCS0=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0
REQ-035 Reset asserted during WR or RDW SHALL abort the access with no RAM write; the first transfer after deassertion SHALL be handled normally.

Verification
REQ-036 64-bit write 0x1122334455667788 to 0x0000_0010, then read -> SRAMWEN=0xFF at SRAMADDR=2; read returns the same value with zero waits.
REQ-037 Byte write 0xAB to 0x0000_0013 (HSIZE=0) -> SRAMWEN=0x08; a subsequent 64-bit read shows 0xAB in bits [31:24] and other bytes unchanged.
REQ-038 Write to 0x18, then back-to-back read of 0x18 -> exactly one HREADYOUT=0 cycle (RDW); read returns the newly written data.
REQ-039 Halfword access at 0x0000_0001 -> ERR1 then ERR2 with HRESP=1; SRAMCS0 stays 0; the next valid read completes OKAY.
REQ-040 Access to 0x0000_2008 -> aliases to SRAMADDR=1.
REQ-041 HRESET pulsed during WR -> SRAMWEN=0 in the same cycle; after release, a read of that address returns the pre-write value.

Source files
------------

// File: rtl/ahbl_sram_ctrl.sv
// AHB-Lite slave bridging a 64-bit bus onto a single-port synchronous SRAM (1024 x 64).
// Reads issue in the address phase; a read that collides with a pending write costs one wait state.
module ahbl_sram_ctrl (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [63:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [63:0] HRDATA,
  input  logic [63:0] SRAMRDATA,
  output logic [7:0]  SRAMWEN,
  output logic [63:0] SRAMWDATA,
  output logic        SRAMCS0,
  output logic [9:0]  SRAMADDR
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRdw,
    StErr1,
    StErr2
  } state_e;

  state_e     state_q;
  logic [9:0] addr_q;
  logic [7:0] lanes_q;
  logic       ready_q;
  logic       resp_q;

  logic       can_accept;
  logic       accept;
  logic       size_ok;
  logic       align_ok;
  logic       xfer_err;
  logic       rd_now;
  logic [7:0] lanes;
  logic       unused_ok;

  assign unused_ok = ^{HADDR[31:13], HTRANS[0]};

  // ERR1 and RDW hold HREADYOUT low, so no new address phase can complete there.
  assign can_accept = (state_q == StIdle) || (state_q == StWr) ||
                      (state_q == StRd)   || (state_q == StErr2);
  assign accept     = HSEL & HREADY & HTRANS[1] & can_accept;

  always_comb begin
    size_ok  = 1'b1;
    align_ok = 1'b1;
    lanes    = 8'h00;
    case (HSIZE)
      3'd0: lanes = 8'h01 << HADDR[2:0];
      3'd1: begin
        lanes    = 8'h03 << HADDR[2:0];
        align_ok = ~HADDR[0];
      end
      3'd2: begin
        lanes    = 8'h0f << HADDR[2:0];
        align_ok = (HADDR[1:0] == 2'b00);
      end
      3'd3: begin
        lanes    = 8'hff;
        align_ok = (HADDR[2:0] == 3'b000);
      end
      default: size_ok = 1'b0;
    endcase
  end

  assign xfer_err = ~(size_ok & align_ok);
  // Read issued straight from the address phase unless the RAM port is busy with a write.
  assign rd_now   = accept & ~xfer_err & ~HWRITE & (state_q != StWr);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lanes_q <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        StErr1: begin
          state_q <= StErr2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        StRdw: begin
          state_q <= StRd;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          if (accept) begin
            if (xfer_err) begin
              state_q <= StErr1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else if (HWRITE) begin
              state_q <= StWr;
              addr_q  <= HADDR[12:3];
              lanes_q <= lanes;
            end else if (state_q == StWr) begin
              state_q <= StRdw;
              addr_q  <= HADDR[12:3];
              ready_q <= 1'b0;
            end else begin
              state_q <= StRd;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    HREADYOUT = ready_q;
    HRESP     = resp_q;
    HRDATA    = '0;
    SRAMCS0   = 1'b0;
    SRAMWEN   = '0;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    // Gate on reset so an in-flight write or address-phase read is dropped immediately.
    if (!HRESET) begin
      case (state_q)
        StWr: begin
          SRAMCS0   = 1'b1;
          SRAMWEN   = lanes_q;
          SRAMADDR  = addr_q;
          SRAMWDATA = HWDATA;
        end
        StRdw: begin
          SRAMCS0  = 1'b1;
          SRAMADDR = addr_q;
        end
        StRd: HRDATA = SRAMRDATA;
        default: ;
      endcase
      if (rd_now) begin
        SRAMCS0  = 1'b1;
        SRAMADDR = HADDR[12:3];
      end
    end
  end

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Bench for ahbl_sram_ctrl: directed cases plus random pipelined AHB traffic checked against
// a byte-level golden memory and the expected wait/response pattern of each transfer.
module tb_ahbl_sram_ctrl;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [63:0] hrdata;
  logic [63:0] sramrdata;
  logic [7:0]  sramwen;
  logic [63:0] sramwdata;
  logic        sramcs0;
  logic [9:0]  sramaddr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [63:0] ram  [1024];
  logic [63:0] gold [1024];
  logic        ram_init;

  // Outstanding data phase as seen by the bench.
  logic        have_dp = 1'b0;
  logic        dp_write, dp_err, dp_rdw, dp_stalled;
  logic [9:0]  dp_word;
  logic [7:0]  dp_lanes;
  logic [63:0] dp_wdata;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  ahbl_sram_ctrl u_dut (
    .HCLK      (hclk),
    .HRESET    (hreset),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hready),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .SRAMRDATA (sramrdata),
    .SRAMWEN   (sramwen),
    .SRAMWDATA (sramwdata),
    .SRAMCS0   (sramcs0),
    .SRAMADDR  (sramaddr)
  );

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) * 32'h9e3779b1, 32'(i) ^ 32'hc0ffee00};
  endfunction

  // Synchronous RAM: read data appears the cycle after a non-write select.
  always @(posedge hclk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (sramcs0) begin
      if (sramwen != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (sramwen[b]) ram[sramaddr][8*b +: 8] <= sramwdata[8*b +: 8];
      end else begin
        sramrdata <= ram[sramaddr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_err(input logic [2:0] size, input logic [2:0] off);
    if (size > 3'd3) return 1'b1;
    return (int'(off) % (1 << size)) != 0;
  endfunction

  function automatic logic [7:0] exp_lanes(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m = 8'h00;
    for (int b = 0; b < 8; b++)
      if (b >= int'(off) && b < int'(off) + (1 << size)) m[b] = 1'b1;
    return m;
  endfunction

  // Present one address phase and run clock cycles until the bench expects it accepted,
  // checking the outstanding data phase and the RAM port each cycle.
  task automatic do_xfer(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] wdata);
    logic done = 1'b0;
    logic new_acc, new_err, new_rd, wr_ok, exp_ready;
    hsel = sel; htrans = trans; hwrite = wr; haddr = addr; hsize = size;
    for (int n = 0; n < 6 && !done; n++) begin
      @(negedge hclk);
      new_acc   = sel && trans[1];
      new_err   = is_err(size, addr[2:0]);
      new_rd    = new_acc && !new_err && !wr;
      wr_ok     = have_dp && dp_write && !dp_err;
      exp_ready = !(have_dp && (dp_err || dp_rdw) && !dp_stalled);
      check_eq("hreadyout", hreadyout, exp_ready);
      check_eq("hresp", hresp, have_dp && dp_err);
      if (wr_ok) begin
        check_eq("wr_cs", sramcs0, 1'b1);
        check_eq("wr_wen", sramwen, dp_lanes);
        check_eq("wr_addr", sramaddr, dp_word);
        check_eq("wr_wdata", sramwdata, dp_wdata);
      end else if (have_dp && dp_rdw && !dp_stalled) begin
        check_eq("rdw_cs", sramcs0, 1'b1);
        check_eq("rdw_wen", sramwen, 8'h00);
        check_eq("rdw_addr", sramaddr, dp_word);
      end else if (exp_ready && new_rd) begin
        check_eq("rd_cs", sramcs0, 1'b1);
        check_eq("rd_wen", sramwen, 8'h00);
        check_eq("rd_addr", sramaddr, addr[12:3]);
      end else begin
        check_eq("idle_cs", sramcs0, 1'b0);
        check_eq("idle_wen", sramwen, 8'h00);
      end
      if (have_dp && !dp_write && !dp_err && exp_ready)
        check_eq("rdata", hrdata, gold[dp_word]);
      else
        check_eq("rdata_zero", hrdata, 64'h0);
      if (exp_ready) begin
        if (wr_ok)
          for (int b = 0; b < 8; b++)
            if (dp_lanes[b]) gold[dp_word][8*b +: 8] = dp_wdata[8*b +: 8];
        have_dp    = new_acc;
        dp_write   = wr;
        dp_err     = new_err;
        dp_rdw     = new_rd && wr_ok;
        dp_stalled = 1'b0;
        dp_word    = addr[12:3];
        dp_lanes   = exp_lanes(size, addr[2:0]);
        dp_wdata   = wdata;
        done       = 1'b1;
      end else begin
        dp_stalled = 1'b1;
      end
      @(posedge hclk);
      #1;
      hwdata = (have_dp && dp_write && !dp_err) ? dp_wdata : 64'h0;
    end
    check_eq("xfer_done", done, 1'b1);
  endtask

  task automatic idle();
    do_xfer(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 64'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, hreadyout, 1'b1);
    check_eq({tag, "_resp"}, hresp, 1'b0);
    check_eq({tag, "_rdata"}, hrdata, 64'h0);
    check_eq({tag, "_cs"}, sramcs0, 1'b0);
    check_eq({tag, "_wen"}, sramwen, 8'h00);
    check_eq({tag, "_addr"}, sramaddr, 10'h0);
    check_eq({tag, "_wdata"}, sramwdata, 64'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz, off;
    logic [9:0]  word;
    int          r;
    hreset = 1'b1; ram_init = 1'b1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = '0; hwdata = '0;
    for (int i = 0; i < 1024; i++) gold[i] = init_word(i);
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge hclk);
    #1;
    ram_init = 1'b0;
    hreset   = 1'b0;

    // 64-bit write then read back
    do_xfer(1'b1, 2'b10, 1'b1, 32'h0000_0010, 3'd3, 64'h1122334455667788);
    idle();
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'd3, 64'h0);
    idle();
    // byte write into lane 3
    do_xfer(1'b1, 2'b10, 1'b1, 32'h0000_0013, 3'd0, 64'h0000_0000_AB00_0000);
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'd3, 64'h0);
    idle();
    // write then back-to-back read of the same word
    do_xfer(1'b1, 2'b10, 1'b1, 32'h0000_0018, 3'd3, 64'hCAFE_F00D_1234_5678);
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0018, 3'd3, 64'h0);
    idle();
    // misaligned halfword, then a valid read
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0001, 3'd1, 64'h0);
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0018, 3'd3, 64'h0);
    idle();
    // aliasing above 8 KB
    do_xfer(1'b1, 2'b10, 1'b1, 32'h0000_2008, 3'd3, 64'h0BAD_BEEF_0000_0001);
    idle();
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0008, 3'd3, 64'h0);
    idle();

    // reset in the WR cycle drops the write
    do_xfer(1'b1, 2'b10, 1'b1, 32'h0000_0020, 3'd3, 64'hFFFF_0000_FFFF_0000);
    hsel = 1'b0; htrans = 2'b00;
    hreset = 1'b1;
    #1;
    check_reset_outputs("rst_wr");
    @(posedge hclk);
    #1;
    hreset = 1'b0; have_dp = 1'b0; hwdata = '0;
    do_xfer(1'b1, 2'b10, 1'b0, 32'h0000_0020, 3'd3, 64'h0);
    idle();

    // random pipelined traffic
    for (int t = 0; t < 600; t++) begin
      word = (($urandom % 8) == 0) ? 10'($urandom % 1024) : 10'($urandom % 8);
      r    = int'($urandom % 10);
      sz   = (r < 9) ? 3'(r % 4) : 3'(4 + $urandom % 4);
      off  = (($urandom % 8) != 0 && sz <= 3'd3) ? 3'(($urandom % 8) & ~((1 << sz) - 1))
                                                 : 3'($urandom % 8);
      a    = {$urandom, 13'h0};
      a    = {a[31:13], word, off};
      do_xfer(($urandom % 8) != 0, 2'($urandom % 4), 1'($urandom % 2), a, sz,
              {$urandom, $urandom});
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
